pipe_sequencer: RTL and testbench

- Central hazard/flow controller for the 5-stage pipeline, placed beside the decode stage.
- Resolves branches against the predictor's IF-time guess and issues a redirect plus a fetch flush on mispredict.
- Detects load-use hazards and generates the freeze and bubble-injection signals.
- Sequences the syscall drain (freeze, drain, one SYS pulse, release) as an explicit FSM, and keeps saturating branch/mispredict statistics.

---
 rtl/pipe_sequencer.sv | 118 +++++++++++
 tb/tb_pipe_sequencer.sv | 209 ++++++++++++++++++++
 2 files changed

// File: rtl/pipe_sequencer.sv
// Hazard/flow controller beside decode: branch redirect on mispredict, load-use
// freeze/bubble, syscall drain sequencing and saturating branch statistics.
module pipe_sequencer #(
  parameter int unsigned DRAIN_CYCLES = 3,
  parameter int unsigned CNT_W        = 16
) (
  input  logic             CLK,
  input  logic             RESET,
  input  logic             id_valid,
  input  logic             id_is_branch,
  input  logic             id_is_taken,
  input  logic [31:0]      id_alt_address,
  input  logic [31:0]      id_pc_plus4,
  input  logic             pred_taken,
  input  logic [31:0]      pred_target,
  input  logic             id_syscall,
  input  logic [4:0]       id_rs,
  input  logic [4:0]       id_rt,
  input  logic             id_uses_rt,
  input  logic             exe_memread,
  input  logic [4:0]       exe_wreg,
  output logic             want_freeze,
  output logic             inject_bubble,
  output logic             redirect_valid,
  output logic [31:0]      redirect_pc,
  output logic             flush_if,
  output logic             sys_out,
  output logic [CNT_W-1:0] branch_count,
  output logic [CNT_W-1:0] mispredict_count
);

  localparam int unsigned DC_W = 3;
  localparam logic [CNT_W-1:0] CNT_MAX = '1;

  typedef enum logic [1:0] {RUN, DRAIN, SYSP, RELEASE} state_t;

  state_t          state;
  logic [DC_W-1:0] drain_cnt;

  logic load_use;
  logic sys_seen;
  logic sys_entry;
  logic resolve;
  logic mispredict;
  logic in_drain;
  logic in_sysp;

  assign load_use = id_valid & exe_memread & (exe_wreg != 5'd0) &
                    ((exe_wreg == id_rs) | (id_uses_rt & (exe_wreg == id_rt)));

  assign in_drain  = (state == DRAIN);
  assign in_sysp   = (state == SYSP);
  assign sys_seen  = (state == RUN) & id_valid & id_syscall;
  assign sys_entry = sys_seen & ~load_use;

  // The instruction in ID is wrong-path while flush_if is high, so skip it.
  assign resolve = (state == RUN) & id_valid & id_is_branch & ~load_use &
                   ~sys_entry & ~flush_if;

  assign mispredict = (id_is_taken != pred_taken) |
                      (id_is_taken & pred_taken & (id_alt_address != pred_target));

  assign want_freeze   = (state != RELEASE) & (load_use | sys_seen | in_drain | in_sysp);
  assign inject_bubble = load_use | in_drain | in_sysp;

  // Syscall drain sequencer; sys_out is high exactly while in SYSP.
  always_ff @(posedge CLK or negedge RESET) begin
    if (!RESET) begin
      state     <= RUN;
      drain_cnt <= '0;
      sys_out   <= 1'b0;
    end else begin
      case (state)
        RUN: begin
          if (sys_entry) begin
            state     <= DRAIN;
            drain_cnt <= DC_W'(DRAIN_CYCLES - 1);
          end
        end
        DRAIN: begin
          if (drain_cnt == '0) begin
            state   <= SYSP;
            sys_out <= 1'b1;
          end else begin
            drain_cnt <= drain_cnt - DC_W'(1);
          end
        end
        SYSP: begin
          state   <= RELEASE;
          sys_out <= 1'b0;
        end
        RELEASE: state <= RUN;
        default: state <= RUN;
      endcase
    end
  end

  // Branch resolution: one-cycle redirect/flush, target held between redirects.
  always_ff @(posedge CLK or negedge RESET) begin
    if (!RESET) begin
      redirect_valid   <= 1'b0;
      flush_if         <= 1'b0;
      redirect_pc      <= '0;
      branch_count     <= '0;
      mispredict_count <= '0;
    end else begin
      redirect_valid <= resolve & mispredict;
      flush_if       <= resolve & mispredict;
      if (resolve & mispredict)
        redirect_pc <= id_is_taken ? id_alt_address : id_pc_plus4;
      if (resolve && branch_count != CNT_MAX)
        branch_count <= branch_count + CNT_W'(1);
      if (resolve && mispredict && mispredict_count != CNT_MAX)
        mispredict_count <= mispredict_count + CNT_W'(1);
    end
  end

endmodule

// File: tb/tb_pipe_sequencer.sv
// Randomized and directed bench for pipe_sequencer against a cycle-count based
// reference model of the hazard, redirect, syscall and statistics rules.
module tb_pipe_sequencer;

  localparam int unsigned D     = 3;
  localparam int unsigned CNT_W = 16;
  localparam int          CMAX  = 65535;

  logic        CLK = 1'b0;
  logic        RESET = 1'b0;
  logic        id_valid, id_is_branch, id_is_taken, pred_taken, id_syscall;
  logic        id_uses_rt, exe_memread;
  logic [31:0] id_alt_address, id_pc_plus4, pred_target;
  logic [4:0]  id_rs, id_rt, exe_wreg;
  logic        want_freeze, inject_bubble, redirect_valid, flush_if, sys_out;
  logic [31:0] redirect_pc;
  logic [CNT_W-1:0] branch_count, mispredict_count;

  pipe_sequencer #(.DRAIN_CYCLES(D), .CNT_W(CNT_W)) dut (
    .CLK(CLK), .RESET(RESET),
    .id_valid(id_valid), .id_is_branch(id_is_branch), .id_is_taken(id_is_taken),
    .id_alt_address(id_alt_address), .id_pc_plus4(id_pc_plus4),
    .pred_taken(pred_taken), .pred_target(pred_target), .id_syscall(id_syscall),
    .id_rs(id_rs), .id_rt(id_rt), .id_uses_rt(id_uses_rt),
    .exe_memread(exe_memread), .exe_wreg(exe_wreg),
    .want_freeze(want_freeze), .inject_bubble(inject_bubble),
    .redirect_valid(redirect_valid), .redirect_pc(redirect_pc), .flush_if(flush_if),
    .sys_out(sys_out), .branch_count(branch_count), .mispredict_count(mispredict_count)
  );

  always #5 CLK = ~CLK;

  int checks = 0;
  int errors = 0;

  // Model: cycles since syscall entry (0 = running), last redirect, counters.
  int          m_phase;
  logic        m_redir;
  logic [31:0] m_pc;
  int          m_bc, m_mc;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, got, exp, $time);
    end
  endtask

  task automatic idle();
    id_valid = 0; id_is_branch = 0; id_is_taken = 0; pred_taken = 0; id_syscall = 0;
    id_uses_rt = 0; exe_memread = 0; id_alt_address = 0; id_pc_plus4 = 0;
    pred_target = 0; id_rs = 0; id_rt = 0; exe_wreg = 0;
  endtask

  task automatic model_reset();
    m_phase = 0; m_redir = 0; m_pc = 0; m_bc = 0; m_mc = 0;
  endtask

  // Called at a falling edge with inputs driven; checks, steps the model, returns at next falling edge.
  task automatic cycle();
    logic lu, run, busy, rel, entry, res, mis;
    #1;
    lu = id_valid && exe_memread && exe_wreg != 0 &&
         (exe_wreg == id_rs || (id_uses_rt && exe_wreg == id_rt));
    run  = (m_phase == 0);
    busy = (m_phase >= 1 && m_phase <= D + 1);
    rel  = (m_phase == D + 2);
    check("want_freeze", 32'(want_freeze), 32'(!rel && (lu || (run && id_valid && id_syscall) || busy)));
    check("inject_bubble", 32'(inject_bubble), 32'(lu || busy));
    check("redirect_valid", 32'(redirect_valid), 32'(m_redir));
    check("flush_if", 32'(flush_if), 32'(m_redir));
    check("redirect_pc", redirect_pc, m_pc);
    check("sys_out", 32'(sys_out), 32'(m_phase == D + 1));
    check("branch_count", 32'(branch_count), 32'(m_bc));
    check("mispredict_count", 32'(mispredict_count), 32'(m_mc));
    entry = run && id_valid && id_syscall && !lu;
    res   = run && id_valid && id_is_branch && !lu && !entry && !m_redir;
    mis   = (id_is_taken != pred_taken) || (id_is_taken && pred_taken && id_alt_address != pred_target);
    m_redir = res && mis;
    if (res && mis) m_pc = id_is_taken ? id_alt_address : id_pc_plus4;
    if (res && m_bc < CMAX) m_bc++;
    if (res && mis && m_mc < CMAX) m_mc++;
    if (entry) m_phase = 1;
    else if (m_phase == D + 2) m_phase = 0;
    else if (m_phase > 0) m_phase++;
    @(negedge CLK);
  endtask

  task automatic do_reset();
    RESET = 0;
    idle();
    #2;
    check("rst_redirect_valid", 32'(redirect_valid), 0);
    check("rst_flush_if", 32'(flush_if), 0);
    check("rst_redirect_pc", redirect_pc, 0);
    check("rst_sys_out", 32'(sys_out), 0);
    check("rst_branch_count", 32'(branch_count), 0);
    check("rst_mispredict_count", 32'(mispredict_count), 0);
    check("rst_want_freeze", 32'(want_freeze), 0);
    model_reset();
    @(negedge CLK);
    RESET = 1;
  endtask

  task automatic branch(input logic tk, input logic pt, input logic [31:0] alt,
                        input logic [31:0] ptgt, input logic [31:0] pc4);
    idle();
    id_valid = 1; id_is_branch = 1; id_is_taken = tk; pred_taken = pt;
    id_alt_address = alt; pred_target = ptgt; id_pc_plus4 = pc4;
  endtask

  initial begin
    int frozen, pulses, bc0;
    idle();
    model_reset();
    @(negedge CLK);
    do_reset();
    idle(); cycle();

    // Correct prediction.
    branch(1, 1, 32'h400100, 32'h400100, 32'h400004); cycle();
    check("ok_redirect", 32'(redirect_valid), 0);
    check("ok_bc", 32'(branch_count), 1);
    check("ok_mc", 32'(mispredict_count), 0);

    // Direction mispredict.
    branch(0, 1, 32'h400100, 32'h400100, 32'h400024); cycle();
    check("dir_redirect", 32'(redirect_valid), 1);
    check("dir_flush", 32'(flush_if), 1);
    check("dir_pc", redirect_pc, 32'h400024);
    check("dir_mc", 32'(mispredict_count), 1);
    idle(); cycle();
    check("dir_one_cycle", 32'(redirect_valid), 0);

    // Target mispredict.
    branch(1, 1, 32'h400200, 32'h400300, 32'h400044); cycle();
    check("tgt_pc", redirect_pc, 32'h400200);
    idle(); cycle();

    // Load-use stall holding a branch, resolved once when it clears.
    bc0 = 32'(branch_count);
    branch(1, 1, 32'h400100, 32'h400100, 32'h400004);
    exe_memread = 1; exe_wreg = 8; id_rs = 8;
    #1;
    check("lu_freeze", 32'(want_freeze), 1);
    check("lu_bubble", 32'(inject_bubble), 1);
    cycle();
    check("lu_no_resolve", 32'(branch_count), 32'(bc0));
    exe_memread = 0; cycle();
    check("lu_resolved", 32'(branch_count), 32'(bc0 + 1));
    idle(); cycle();
    check("lu_once", 32'(branch_count), 32'(bc0 + 1));

    // Syscall drain sequence.
    frozen = 0; pulses = 0;
    idle(); id_valid = 1; id_syscall = 1;
    for (int i = 0; i < D + 3; i++) begin
      #1;
      frozen += int'(want_freeze);
      pulses += int'(sys_out);
      cycle();
    end
    check("sys_frozen", 32'(frozen), 32'(D + 2));
    check("sys_pulses", 32'(pulses), 1);
    idle(); cycle(); cycle();

    // Reset in the middle of a drain.
    idle(); id_valid = 1; id_syscall = 1; cycle();
    idle(); cycle();
    do_reset();
    for (int i = 0; i < D + 4; i++) begin
      cycle();
      check("rst_drain_no_sys", 32'(sys_out), 0);
    end

    // Randomized traffic.
    for (int i = 0; i < 3000; i++) begin
      idle();
      id_valid       = ($urandom_range(0, 9) < 8);
      id_is_branch   = ($urandom_range(0, 9) < 4);
      id_is_taken    = 1'($urandom);
      pred_taken     = 1'($urandom);
      id_alt_address = ($urandom_range(0, 1) != 0) ? 32'h400100 : 32'h400200;
      pred_target    = ($urandom_range(0, 1) != 0) ? 32'h400100 : 32'h400200;
      id_pc_plus4    = 32'h400000 + 32'($urandom_range(0, 255)) * 4;
      id_syscall     = ($urandom_range(0, 99) < 3);
      id_rs          = 5'($urandom_range(0, 3));
      id_rt          = 5'($urandom_range(0, 3));
      id_uses_rt     = 1'($urandom);
      exe_memread    = ($urandom_range(0, 9) < 3);
      exe_wreg       = 5'($urandom_range(0, 3));
      cycle();
    end

    // Saturation of the branch counter.
    do_reset();
    branch(1, 1, 32'h400100, 32'h400100, 32'h400004);
    for (int i = 0; i < CMAX; i++) cycle();
    check("sat_reach", 32'(branch_count), 32'h0000FFFF);
    cycle();
    check("sat_hold", 32'(branch_count), 32'h0000FFFF);
    check("sat_mc", 32'(mispredict_count), 0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
